// File: rtl/dcache_responder.sv
// dcache_responder: fixed-latency DMEM responder with LR/SC, exceptions, kill and periodic NACK/replay
module dcache_responder #(
  parameter int MEM_ADDR_BITS = 10,
  parameter int LATENCY = 3,
  parameter int NACK_PERIOD = 0
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        dmem_req_valid_i,
  input  logic [4:0]  dmem_req_cmd_i,
  input  logic [3:0]  dmem_op_type_i,
  input  logic [39:0] dmem_req_addr_i,
  input  logic [63:0] dmem_req_data_i,
  input  logic [7:0]  dmem_req_tag_i,
  input  logic        dmem_req_invalidate_lr_i,
  input  logic        dmem_req_kill_i,
  output logic        dmem_req_ready_o,
  output logic        dmem_resp_valid_o,
  output logic [63:0] dmem_resp_data_o,
  output logic [7:0]  dmem_resp_tag_o,
  output logic        dmem_resp_nack_o,
  output logic        dmem_resp_replay_o,
  output logic        dmem_ordered_o,
  output logic        dmem_xcpt_ma_ld_o,
  output logic        dmem_xcpt_ma_st_o,
  output logic        dmem_xcpt_pf_ld_o,
  output logic        dmem_xcpt_pf_st_o
);
  typedef enum logic [1:0] {IDLE, CHECK, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [4:0]  cmd;
  logic [3:0]  op;
  logic [39:0] addr;
  logic [63:0] wdata;
  logic [7:0]  tag;
  logic [3:0]  cnt;
  logic [15:0] nack_cnt;
  logic        resv_v;
  logic [MEM_ADDR_BITS-1:0] resv_a;
  logic        rec_v;
  logic [47:0] rec;
  logic [63:0] mem [2**MEM_ADDR_BITS];
  logic is_st, is_lr, is_sc, is_ld, mis, oor, nack_hit, rec_hit, sc_ok, in_resp, in_chk, pass, wr;
  logic [1:0]  size;
  logic [2:0]  off;
  logic [MEM_ADDR_BITS-1:0] idx;
  logic [63:0] rd, sh, ld_data, wd;
  logic [7:0]  be_mask, be;
  // Request decode, exception checks, load extraction and store byte lanes
  always_comb begin
    is_st    = cmd == 5'd1;
    is_lr    = cmd == 5'd6;
    is_sc    = cmd == 5'd7;
    is_ld    = ~is_st & ~is_sc;
    size     = op[1:0];
    off      = addr[2:0];
    idx      = addr[MEM_ADDR_BITS+2:3];
    mis      = ((off & ((3'd1 << size) - 3'd1)) != 3'd0) || ((is_lr | is_sc) && !size[1]);
    oor      = |addr[39:MEM_ADDR_BITS+3];
    in_chk   = state == CHECK;
    in_resp  = state == RESP;
    pass     = in_chk & ~mis & ~oor & ~dmem_req_kill_i;
    nack_hit = (NACK_PERIOD != 0) && (nack_cnt == 16'(NACK_PERIOD));
    rec_hit  = rec_v && (rec == {addr, tag});
    sc_ok    = resv_v && (resv_a == idx) && !dmem_req_invalidate_lr_i;
    rd       = mem[idx];
    sh       = rd >> {off, 3'b000};
    ld_data  = size == 2'd0 ? {{56{~op[2] & sh[7]}}, sh[7:0]} :
               size == 2'd1 ? {{48{~op[2] & sh[15]}}, sh[15:0]} :
               size == 2'd2 ? {{32{~op[2] & sh[31]}}, sh[31:0]} : rd;
    be_mask  = size == 2'd0 ? 8'h01 : size == 2'd1 ? 8'h03 : size == 2'd2 ? 8'h0f : 8'hff;
    be       = 8'(be_mask << off);
    wd       = 64'(wdata << {off, 3'b000});
    wr       = in_resp & ~nack_hit & (is_st | (is_sc & sc_ok));
  end
  // Outputs are decoded from the current state, so reset clears them immediately
  always_comb begin
    dmem_req_ready_o   = state == IDLE;
    dmem_ordered_o     = state == IDLE;
    dmem_resp_valid_o  = in_resp;
    dmem_resp_tag_o    = in_resp ? tag : 8'd0;
    dmem_resp_nack_o   = in_resp & nack_hit;
    dmem_resp_replay_o = in_resp & ~nack_hit & rec_hit;
    dmem_resp_data_o   = (!in_resp || nack_hit || is_st) ? 64'd0 : is_sc ? {63'd0, ~sc_ok} : ld_data;
    dmem_xcpt_ma_ld_o  = in_chk & mis & is_ld;
    dmem_xcpt_ma_st_o  = in_chk & mis & ~is_ld;
    dmem_xcpt_pf_ld_o  = in_chk & ~mis & oor & is_ld;
    dmem_xcpt_pf_st_o  = in_chk & ~mis & oor & ~is_ld;
  end
  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = dmem_req_valid_i ? CHECK : IDLE;
      CHECK:   state_nx = !pass ? IDLE : (LATENCY == 2) ? RESP : WAIT;
      WAIT:    state_nx = cnt == 4'd1 ? RESP : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  // State, request capture, latency/NACK counters, NACK record and reservation
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      cmd      <= '0;
      op       <= '0;
      addr     <= '0;
      wdata    <= '0;
      tag      <= '0;
      cnt      <= '0;
      nack_cnt <= '0;
      resv_v   <= 1'b0;
      resv_a   <= '0;
      rec_v    <= 1'b0;
      rec      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && dmem_req_valid_i) begin
        cmd   <= dmem_req_cmd_i;
        op    <= dmem_op_type_i;
        addr  <= dmem_req_addr_i;
        wdata <= dmem_req_data_i;
        tag   <= dmem_req_tag_i;
      end
      if (pass) begin
        cnt      <= 4'(LATENCY - 2);
        nack_cnt <= nack_cnt + 16'd1;
      end
      if (state == WAIT) cnt <= cnt - 4'd1;
      if (in_resp && nack_hit) begin
        nack_cnt <= '0;
        rec_v    <= 1'b1;
        rec      <= {addr, tag};
      end
      if (in_resp && !nack_hit && rec_hit) rec_v <= 1'b0;
      if (dmem_req_invalidate_lr_i) resv_v <= 1'b0;
      else if (in_resp && !nack_hit) begin
        if (is_lr) begin
          resv_v <= 1'b1;
          resv_a <= idx;
        end else if (is_sc || (is_st && resv_a == idx)) resv_v <= 1'b0;
      end
    end
  end
  // Scratchpad writes with byte enables; contents survive reset
  always_ff @(posedge clk_i) begin
    if (wr)
      for (int i = 0; i < 8; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
Behavioural, synthesizable data-memory responder that sits at the far end of the DMEM request/response protocol driven by the core's dcache interface. It plays the D-cache side for core-level simulation and FPGA bring-up. It accepts one request at a time and answers after a fixed latency from a local dword-wide scratchpad. It models LR/SC reservations, misaligned and out-of-range exceptions, kill, and a periodic NACK/replay pattern.

Parameters:
MEM_ADDR_BITS, 10, log2 of the scratchpad depth in 64-bit dwords (1024 dwords = 8 KiB)
LATENCY, 3, cycles from the acceptance edge to the response cycle; legal range 2..15
NACK_PERIOD, 0, every Nth accepted non-excepting request is NACKed; 0 disables NACKs

Ports:
clk_i  in  1  core clock
rstn_i  in  1  asynchronous active-low reset
dmem_req_valid_i  in  1  request valid
dmem_req_cmd_i  in  5  0=load, 1=store, 6=LR, 7=SC; other codes are treated as load
dmem_op_type_i  in  4  [1:0] size (0=B, 1=H, 2=W, 3=D); [2] unsigned load
dmem_req_addr_i  in  40  byte address
dmem_req_data_i  in  64  store data, right-aligned
dmem_req_tag_i  in  8  request tag
dmem_req_invalidate_lr_i  in  1  clears the reservation in any cycle it is high
dmem_req_kill_i  in  1  cancels the request accepted in the previous cycle
dmem_req_ready_o  out  1  responder can accept a request
dmem_resp_valid_o  out  1  one-cycle response pulse
dmem_resp_data_o  out  64  load data, extended to 64 bits; SC result; 0 for stores
dmem_resp_tag_o  out  8  echoed tag
dmem_resp_nack_o  out  1  request refused; no side effects; requester must retry
dmem_resp_replay_o  out  1  response belongs to a retried, previously NACKed request
dmem_ordered_o  out  1  no request is outstanding
dmem_xcpt_ma_ld_o, dmem_xcpt_ma_st_o  out  1 each  misaligned load / store (LR counts as load; store and SC count as store)
dmem_xcpt_pf_ld_o, dmem_xcpt_pf_st_o  out  1 each  address outside the scratchpad

Behaviour:
- Reset (rstn_i low, asynchronous):
  - State goes to IDLE; the reservation, NACK counter and NACK record are cleared.
  - ready_o=1 and ordered_o=1; every other output is 0.
  - Scratchpad contents are not reset.
  - Reset asserted mid-operation drops the request: no response and no write.
- State IDLE:
  - ready_o=1 and ordered_o=1.
  - Acceptance happens on a clock edge with valid_i & ready_o. The responder registers cmd, op_type, addr, data and tag, then moves to CHECK.
- State CHECK (cycle 1 after acceptance); ready_o=0, ordered_o=0:
  - Misaligned (addr not a multiple of 2^size, or LR/SC with size below W): pulse the matching ma_ld/ma_st for this cycle, then return to IDLE. No response, no write.
  - Otherwise, out of range (addr[39:MEM_ADDR_BITS+3] != 0): pulse pf_ld/pf_st, then return to IDLE. Misalignment takes priority over out-of-range.
  - Otherwise, kill_i high: return to IDLE silently. kill_i in any other cycle is ignored, and kill never suppresses an exception.
  - Otherwise: increment the NACK counter, load the latency counter with LATENCY-2, and go to WAIT.
- State WAIT:
  - Counter decrements each cycle. On reaching 0, go to RESP.
  - The response therefore appears exactly LATENCY cycles after the acceptance edge.
- State RESP (one cycle); resp_valid_o=1 and resp_tag_o=tag, then return to IDLE:
  - NACK case: NACK_PERIOD!=0 and the counter equals NACK_PERIOD. Drive nack_o=1 and data 0, with no side effects. Reset the counter to 0 and record {addr, tag} as the NACK record.
  - Otherwise, if {addr, tag} matches a valid NACK record, drive replay_o=1 and clear the record.
  - Load: read the dword at addr[MEM_ADDR_BITS+2:3]. Select the bytes at addr[2:0] and sign- or zero-extend per op_type[2]. D-size is passed through unchanged.
  - Store: write the low 2^size bytes of data to byte offset addr[2:0] using byte enables; resp data is 0.
  - A store or successful SC whose dword matches the reservation dword clears the reservation.
  - LR: behaves as a load and sets the reservation {valid, dword address}.
  - SC: succeeds only if the reservation is valid, the dword addresses match, and invalidate_lr_i was not seen since the LR. On success it writes and returns data 0; on failure it returns 1 with no write. The reservation is cleared in both cases.
- Simultaneous events: invalidate_lr_i high in the RESP cycle of an SC makes that SC fail. A new valid_i while ready_o=0 is ignored; the requester must hold it.
- Exceptions and responses are mutually exclusive per request.

Test Plan:
- Directed cases:
  1. Store D 0x1122334455667788 at 0x100 (tag 5), then load D at 0x100 (tag 6). Required: both resp_valid pulses occur at acceptance+3, tag 6 returns data 0x1122334455667788, and ready_o is low for 3 cycles per request.
  2. Load B signed at 0x107 and load H unsigned at 0x106 after case 1. Required: data 0x0000000000000011 and 0x0000000000001122 respectively.
  3. Load W at 0x102. Required: ma_ld pulse at cycle 1, no resp_valid. Store D at 0x10000. Required: pf_st pulse at cycle 1, no resp_valid.
  4. Load accepted with kill_i high in cycle 1. Required: no response, ordered_o=1 again at cycle 2. Kill held high in cycle 2 of another load: that response is still delivered.
  5. LR W at 0x200, then SC W 0xAB at 0x200. Required: SC resp data 0 and memory holds 0xAB. Repeat LR, pulse invalidate_lr_i, then SC. Required: SC data 1 and memory unchanged.
  6. With NACK_PERIOD=2, issue loads A and B, then retry B with the same addr and tag. Required: B gets nack_o=1, and the retry gets resp data with replay_o=1. Also assert rstn_i low during WAIT: required outputs go to reset values immediately and no response follows.
